// File: rtl/lieat_wbck_pkg.sv
// Shared definitions for the writeback arbiter: unit indices, one-hot op encoding, widths.
// LIEAT_WBCK_COM_PRIO_EN selects the com-priority variant of the round-robin pointer range.
package lieat_wbck_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX   = 5;
    localparam int NUM_UNITS = 5;

    localparam logic [2:0] UNIT_COM    = 3'd0;
    localparam logic [2:0] UNIT_LSU    = 3'd1;
    localparam logic [2:0] UNIT_MULDIV = 3'd2;
    localparam logic [2:0] UNIT_VPU    = 3'd3;
    localparam logic [2:0] UNIT_FPU    = 3'd4;

    // Same encoding is decoded by the dependency tracker's retire logic.
    typedef logic [NUM_UNITS-1:0] wbck_op_t;

`ifdef LIEAT_WBCK_COM_PRIO_EN
    localparam logic [2:0] PTR_LO = UNIT_LSU;
`else
    localparam logic [2:0] PTR_LO = UNIT_COM;
`endif

    function automatic wbck_op_t unit_onehot(input logic [2:0] idx);
        return wbck_op_t'(1) << idx;
    endfunction

    function automatic logic [2:0] ptr_next(input logic [2:0] idx);
        return (idx == UNIT_FPU) ? PTR_LO : idx + 3'd1;
    endfunction

endpackage

// File: rtl/lieat_wbck_rr_pick.sv
// Combinational one-hot picker: first requester found scanning from ptr upward, wrapping 4->0.
module lieat_wbck_rr_pick
    import lieat_wbck_pkg::*;
(
    input  logic [NUM_UNITS-1:0] req_i,
    input  logic [2:0]           ptr_i,
    output logic [NUM_UNITS-1:0] gnt_o,
    output logic [2:0]           idx_o
);

    always_comb begin
        logic       found;
        logic [3:0] j;
        gnt_o = '0;
        idx_o = ptr_i;
        found = 1'b0;
        j     = '0;
        for (int off = 0; off < NUM_UNITS; off++) begin
            j = {1'b0, ptr_i} + 4'(off);
            if (j >= 4'(NUM_UNITS)) j = j - 4'(NUM_UNITS);
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j[2:0];
            end
        end
    end

endmodule

// File: rtl/lieat_wbck_arb.sv
// Writeback arbiter: grants one of five units per cycle into a registered regfile write stage.
// Define LIEAT_WBCK_COM_PRIO_EN to give com absolute priority over a 4-way round-robin.
module lieat_wbck_arb
    import lieat_wbck_pkg::*;
#(
    parameter int DW = XLEN,
    parameter int AW = REG_IDX
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          com_wb_valid,
    output logic          com_wb_ready,
    input  logic [AW-1:0] com_wb_rd,
    input  logic          com_wb_rdwen,
    input  logic [DW-1:0] com_wb_data,
    input  logic          lsu_wb_valid,
    output logic          lsu_wb_ready,
    input  logic [AW-1:0] lsu_wb_rd,
    input  logic          lsu_wb_rdwen,
    input  logic [DW-1:0] lsu_wb_data,
    input  logic          muldiv_wb_valid,
    output logic          muldiv_wb_ready,
    input  logic [AW-1:0] muldiv_wb_rd,
    input  logic          muldiv_wb_rdwen,
    input  logic [DW-1:0] muldiv_wb_data,
    input  logic          vpu_wb_valid,
    output logic          vpu_wb_ready,
    input  logic [AW-1:0] vpu_wb_rd,
    input  logic          vpu_wb_rdwen,
    input  logic [DW-1:0] vpu_wb_data,
    input  logic          fpu_wb_valid,
    output logic          fpu_wb_ready,
    input  logic [AW-1:0] fpu_wb_rd,
    input  logic          fpu_wb_rdwen,
    input  logic [DW-1:0] fpu_wb_data,
    output logic          wbck_valid,
    output wbck_op_t      wbck_op,
    output logic [AW-1:0] wbck_rd,
    output logic          wbck_rdwen,
    output logic [DW-1:0] wbck_data,
    output logic          arb_idle
);

    logic [NUM_UNITS-1:0] valids, rdwens, rr_req, rr_gnt, gnt, ready;
    logic [2:0]           rr_idx, ptr_q, ptr_d;
    logic                 rr_win, take;
    logic [AW-1:0]        rd_a   [NUM_UNITS];
    logic [DW-1:0]        data_a [NUM_UNITS];
    logic [AW-1:0]        sel_rd;
    logic [DW-1:0]        sel_data;
    logic                 sel_rdwen;

    logic                 valid_q, valid_d, rdwen_q, rdwen_d;
    wbck_op_t             op_q, op_d;
    logic [AW-1:0]        rd_q, rd_d;
    logic [DW-1:0]        data_q, data_d;

    assign valids = {fpu_wb_valid, vpu_wb_valid, muldiv_wb_valid, lsu_wb_valid, com_wb_valid};
    assign rdwens = {fpu_wb_rdwen, vpu_wb_rdwen, muldiv_wb_rdwen, lsu_wb_rdwen, com_wb_rdwen};
    assign rd_a   = '{com_wb_rd, lsu_wb_rd, muldiv_wb_rd, vpu_wb_rd, fpu_wb_rd};
    assign data_a = '{com_wb_data, lsu_wb_data, muldiv_wb_data, vpu_wb_data, fpu_wb_data};

`ifdef LIEAT_WBCK_COM_PRIO_EN
    // com bypasses the rotation; the pointer only ever covers lsu..fpu.
    assign rr_req = valids & ~unit_onehot(UNIT_COM);
    assign gnt    = valids[UNIT_COM] ? unit_onehot(UNIT_COM) : rr_gnt;
    assign rr_win = ~valids[UNIT_COM] & (|rr_gnt);
`else
    assign rr_req = valids;
    assign gnt    = rr_gnt;
    assign rr_win = |rr_gnt;
`endif

    lieat_wbck_rr_pick u_pick (
        .req_i (rr_req),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx)
    );

    // No grant is taken while reset is low, so requesters simply keep waiting.
    assign ready = gnt & {NUM_UNITS{reset}};
    assign take  = |ready;

    assign com_wb_ready    = ready[UNIT_COM];
    assign lsu_wb_ready    = ready[UNIT_LSU];
    assign muldiv_wb_ready = ready[UNIT_MULDIV];
    assign vpu_wb_ready    = ready[UNIT_VPU];
    assign fpu_wb_ready    = ready[UNIT_FPU];

    always_comb begin
        sel_rd    = '0;
        sel_data  = '0;
        sel_rdwen = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (gnt[k]) begin
                sel_rd    = sel_rd | rd_a[k];
                sel_data  = sel_data | data_a[k];
                sel_rdwen = sel_rdwen | rdwens[k];
            end
        end
    end

    always_comb begin
        ptr_d   = (take && rr_win) ? ptr_next(rr_idx) : ptr_q;
        valid_d = take;
        op_d    = take ? gnt : '0;
        rdwen_d = take & sel_rdwen;
        rd_d    = take ? sel_rd : rd_q;
        data_d  = take ? sel_data : data_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_q   <= PTR_LO;
            valid_q <= 1'b0;
            op_q    <= '0;
            rdwen_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            rdwen_q <= rdwen_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    assign wbck_valid = valid_q;
    assign wbck_op    = op_q;
    assign wbck_rd    = rd_q;
    assign wbck_rdwen = rdwen_q;
    assign wbck_data  = data_q;
    assign arb_idle   = ~(|valids) & ~valid_q;

endmodule

// File: doc/lieat_wbck_arb.md
# lieat_wbck_arb

Writeback arbiter between the five execution units (com, lsu, muldiv, vpu, fpu) and the single integer register-file write port. Each cycle it grants at most one unit and registers that unit's result into the writeback stage. The registered result drives the regfile write and the `wbck_valid`/`wbck_op` retire inputs of the decode-stage dependency tracker. Arbitration is round-robin by default, so no long-latency unit is starved.

## Interface
Parameters:
- `DW`, default 32 (`XLEN): result data width.
- `AW`, default 5 (`REG_IDX): register index width.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `<u>_wb_valid`  in  1  unit u has a result; u ∈ {com, lsu, muldiv, vpu, fpu}.
- `<u>_wb_ready`  out  1  grant to unit u; the transfer occurs when valid & ready.
- `<u>_wb_rd`  in  AW  destination register of unit u.
- `<u>_wb_rdwen`  in  1  unit u writes rd; 0 for stores, branches and similar.
- `<u>_wb_data`  in  DW  result data of unit u.
- `wbck_valid`  out  1  writeback stage holds a result this cycle.
- `wbck_op`  out  5  one-hot source of the result: bit0 com, bit1 lsu, bit2 muldiv, bit3 vpu, bit4 fpu.
- `wbck_rd`  out  AW  destination register.
- `wbck_rdwen`  out  1  regfile write enable; equals `wbck_valid & captured rdwen`.
- `wbck_data`  out  DW  write data.
- `arb_idle`  out  1  no unit requesting and `wbck_valid` low.

## Operation
- Requests with `rdwen=0` are arbitrated like any other; the dependency tracker needs the retire pulse.
- The downstream port always accepts, so there is no output backpressure. The output register reloads every cycle.
- Grant vector is one-hot or zero, and is combinational from the current valids and the pointer `ptr` (3 bits, values 0..4 in the bit order of `wbck_op`).
- Round-robin: scan the units starting at index `ptr`, wrapping 4→0. The first requesting unit wins.
- On a grant to unit k, `ptr` ← k+1 (mod 5). With no grant, `ptr` holds.
- The winner's `ready` is high in the same cycle; all losers see `ready=0` and must hold their valid and payload stable.
- Output register: if any unit is granted, capture {onehot(k), rd, rdwen, data} and set `wbck_valid=1`. Otherwise set `wbck_valid=0`; `wbck_op` and `wbck_rdwen` are forced to 0, and rd/data hold their previous values.
- No flush input. A result granted here has already passed its unit's flush point, so it always retires.
- Reset (`reset=0` at an edge) sets `ptr=0`, `wbck_valid=0`, `wbck_op=0`, `wbck_rdwen=0`, `wbck_rd=0`, `wbck_data=0`. All `*_wb_ready` are forced to 0 while reset is low.
- Reset asserted mid-stream: a pending grant in that cycle is not taken; the requester keeps its valid high.

## Timing
- Latency: a handshake on edge N gives `wbck_valid=1` during cycle N+1, for exactly one cycle per transfer.
- Throughput: one result per cycle. Back-to-back grants to the same unit are allowed when it is the only requester.
- With all five units requesting continuously, each unit receives exactly one grant in every 5 consecutive cycles.
- `arb_idle` is combinational: `~|valids & ~wbck_valid`. It is 1 out of reset.

## Configuration
- `LIEAT_WBCK_COM_PRIO_EN` defined:
  - com has absolute priority; whenever `com_wb_valid=1` it is granted.
  - The round-robin scans only lsu..fpu (indices 1..4, wrap 4→1); `ptr` resets to 1 and is not updated on a com grant.
  - Non-com units may starve under sustained com traffic. This is accepted because com is single-cycle.
- Undefined: pure 5-way round-robin as described in Operation.

## Structure
- Shared package/defines: unit index constants (COM=0, LSU=1, MULDIV=2, VPU=3, FPU=4), the 5-bit one-hot `wbck_op` encoding (shared with the dependency tracker), `XLEN`, `REG_IDX`.
- Sub-module `lieat_wbck_rr_pick`: combinational one-hot picker with a rotating start index. It takes a request vector and `ptr`, and returns the grant vector and winner index.
- Registers use the existing general DFF-with-load primitive for the output stage.

## Test plan
- Reset, then idle → all outputs 0, `arb_idle=1`, `ptr=0`. After `lsu_wb_valid=1`, rd=3, data=0xA5 → `lsu_wb_ready=1` in the same cycle; next cycle `wbck_valid=1`, `wbck_op=5'b00010`, `wbck_rd=3`, `wbck_data=0xA5`, `wbck_rdwen=1`.
- All five units valid for 10 cycles from reset → grant order com, lsu, muldiv, vpu, fpu, com, …; each unit granted exactly twice.
- muldiv and fpu valid, `ptr=3` → fpu granted first, then muldiv (wrap-around). muldiv holds its payload unchanged while waiting.
- Store with `lsu_wb_rdwen=0` → `wbck_valid=1`, `wbck_op=5'b00010`, `wbck_rdwen=0`.
- `reset` pulled low while com and vpu are valid → no ready asserted; after release, `wbck_valid=0` for one cycle, then com is granted (ptr=0).
- With `LIEAT_WBCK_COM_PRIO_EN`, com continuously valid plus vpu valid → com granted every cycle and vpu never granted. Dropping com for one cycle → vpu granted in that cycle.
